// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types for the backing-memory arbiter
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } requester_t;

  localparam int DEF_LINE_WORDS = 4;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin picker between I-side and D-side
module rr_arb2
  import mem_pkg::*;
(
  input  logic       i_req_ic,
  input  logic       i_req_dc,
  input  requester_t i_last_grant,
  output requester_t o_grant,
  output logic       o_grant_en
);

  always_comb begin
    o_grant_en = i_req_ic | i_req_dc;
    o_grant    = REQ_I;
    // On a tie the side that was not served last wins.
    if (i_req_ic && i_req_dc) begin
      o_grant = (i_last_grant == REQ_I) ? REQ_D : REQ_I;
    end else if (i_req_dc) begin
      o_grant = REQ_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - serialises I-side and D-side line bursts onto one memory port
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WORDS = DEF_LINE_WORDS
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_req_i,
  input  logic [ADDR_WIDTH-1:0]         i_addr_i,
  output logic                          i_rvalid_o,
  output logic                          i_done_o,
  input  logic                          d_req_i,
  input  logic                          d_we_i,
  input  logic [ADDR_WIDTH-1:0]         d_addr_i,
  input  logic [DATA_WIDTH-1:0]         d_wdata_i,
  output logic                          d_rvalid_o,
  output logic                          d_done_o,
  output logic [DATA_WIDTH-1:0]         rdata_o,
  output logic [$clog2(LINE_WORDS)-1:0] beat_o,
  output logic                          i_stall_o,
  output logic                          d_stall_o,
  output logic                          mem_valid_o,
  output logic                          mem_we_o,
  output logic [ADDR_WIDTH-1:0]         mem_addr_o,
  output logic [DATA_WIDTH-1:0]         mem_wdata_o,
  input  logic                          mem_ready_i,
  input  logic [DATA_WIDTH-1:0]         mem_rdata_i
);

  localparam int BW = $clog2(LINE_WORDS);
  localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(DATA_WIDTH / 8);

  arb_state_t             r_state, w_state_nxt;
  requester_t             r_last_grant, w_last_nxt;
  logic [BW-1:0]          r_beat, w_beat_nxt;
  logic [ADDR_WIDTH-1:0]  r_base, w_base_nxt;
  logic                   r_we, w_we_nxt;

  requester_t             w_grant;
  logic                   w_grant_en;
  logic                   w_busy_i, w_busy_d, w_busy;
  logic                   w_last_beat;
  logic [ADDR_WIDTH-1:0]  w_offset;

  rr_arb2 u_rr_arb2 (
    .i_req_ic     (i_req_i),
    .i_req_dc     (d_req_i),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant),
    .o_grant_en   (w_grant_en)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_last_grant <= REQ_I;
      r_beat       <= '0;
      r_base       <= '0;
      r_we         <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_nxt;
      r_beat       <= w_beat_nxt;
      r_base       <= w_base_nxt;
      r_we         <= w_we_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last_grant;
    w_beat_nxt  = r_beat;
    w_base_nxt  = r_base;
    w_we_nxt    = r_we;
    case (r_state)
      IDLE: begin
        if (w_grant_en) begin
          w_state_nxt = (w_grant == REQ_D) ? BUSY_D : BUSY_I;
          w_last_nxt  = w_grant;
          w_beat_nxt  = '0;
          w_base_nxt  = (w_grant == REQ_D) ? d_addr_i : i_addr_i;
          w_we_nxt    = (w_grant == REQ_D) && d_we_i;
        end
      end
      BUSY_I, BUSY_D: begin
        // The counter wraps to 0 on the final beat since LINE_WORDS is a power of two.
        if (mem_ready_i) begin
          w_beat_nxt = r_beat + BW'(1);
          if (w_last_beat) w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_busy_i    = (r_state == BUSY_I);
  assign w_busy_d    = (r_state == BUSY_D);
  assign w_busy      = w_busy_i | w_busy_d;
  assign w_last_beat = (r_beat == BW'(LINE_WORDS - 1));
  assign w_offset    = ADDR_WIDTH'(r_beat) * STRIDE;

  assign mem_valid_o = w_busy;
  assign mem_we_o    = w_busy_d & r_we;
  assign mem_addr_o  = w_busy ? (r_base + w_offset) : '0;
  assign mem_wdata_o = (w_busy_d && r_we) ? d_wdata_i : '0;
  assign beat_o      = r_beat;

  assign i_rvalid_o  = w_busy_i & mem_ready_i;
  assign d_rvalid_o  = w_busy_d & mem_ready_i & ~r_we;
  assign i_done_o    = w_busy_i & mem_ready_i & w_last_beat;
  assign d_done_o    = w_busy_d & mem_ready_i & w_last_beat;

  // Pass-through terms are held low while reset is asserted so every output reads 0.
  assign rdata_o     = rst_n ? mem_rdata_i : '0;
  assign i_stall_o   = rst_n & i_req_i & ~i_done_o;
  assign d_stall_o   = rst_n & d_req_i & ~d_done_o;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single backing-memory port between the instruction-cache refill path (I-side, read-only) and the data-cache refill/writeback path (D-side, read or write). It sits below both caches in the pipelined core. It serialises whole cache-line bursts using round-robin arbitration and produces the per-side stall terms that feed the hazard unit's `CacheStall` input.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, byte address width
- `DATA_WIDTH`, 32, word width; the address stride per beat is `DATA_WIDTH/8`
- `LINE_WORDS`, 4, beats per burst; must be a power of two and ≥2

Ports:
- `clk` in 1: single clock
- `rst_n` in 1: asynchronous, active-low reset
- `i_req_i` in 1: I-side line-read request
- `i_addr_i` in ADDR_WIDTH: I-side line base address
- `i_rvalid_o` out 1: I-side read beat valid
- `i_done_o` out 1: I-side burst complete (one-cycle pulse)
- `d_req_i` in 1: D-side request
- `d_we_i` in 1: D-side write (1) or read (0)
- `d_addr_i` in ADDR_WIDTH: D-side line base address
- `d_wdata_i` in DATA_WIDTH: write word for current beat `beat_o`
- `d_rvalid_o` out 1: D-side read beat valid
- `d_done_o` out 1: D-side burst complete (one-cycle pulse)
- `rdata_o` out DATA_WIDTH: read data to both sides; qualify with `*_rvalid_o`
- `beat_o` out $clog2(LINE_WORDS): current beat index
- `i_stall_o` out 1: I-side request outstanding
- `d_stall_o` out 1: D-side request outstanding
- `mem_valid_o` out 1: memory access request
- `mem_we_o` out 1: memory write
- `mem_addr_o` out ADDR_WIDTH: memory word address (byte units)
- `mem_wdata_o` out DATA_WIDTH: memory write data
- `mem_ready_i` in 1: memory completes current beat; rdata is valid this cycle
- `mem_rdata_i` in DATA_WIDTH: memory read data

## Operation
- States: `IDLE`, `BUSY_I`, `BUSY_D`.
- **IDLE:**
  - Only one request pending: grant it.
  - Both pending: grant the side not in `last_grant`. `last_grant` resets to I, so D wins the first tie.
  - On grant: latch base address (and `we` for D), clear the beat counter, set `last_grant`.
- **BUSY_x:**
  - `mem_valid_o`=1 and `mem_addr_o` = base + beat×(DATA_WIDTH/8). Width wraps modulo 2^ADDR_WIDTH.
  - `mem_we_o` = latched `we` in `BUSY_D`, 0 in `BUSY_I`.
  - `mem_wdata_o` = `d_wdata_i` in `BUSY_D` write, else 0.
  - Each `mem_ready_i` cycle: the owner's `rvalid` =1 for reads (never for writes), and the beat counter increments.
  - On beat `LINE_WORDS-1`: the owner's `done` =1 that cycle, the counter wraps to 0, and the state returns to `IDLE`.
- `rdata_o` passes `mem_rdata_i` through combinationally.
- `i_stall_o` = `i_req_i` & ~`i_done_o`. `d_stall_o` = `d_req_i` & ~`d_done_o`.
- **Requester rules:**
  - Requesters hold `req` and attributes until `done`.
  - `req` must be low the cycle after `done`, unless the requester intends a new burst.
  - Address and `we` changes after grant are ignored.
- `mem_ready_i` outside BUSY is ignored.
- Dropping `req` mid-burst does not abort it; the burst runs to completion and `done` still pulses.

## Timing
- Reset (async, `rst_n`=0) forces:
  - state=`IDLE`, `last_grant`=I, beat=0
  - every output 0, including `mem_valid_o`
- Reset takes effect immediately mid-burst; no partial completion is signalled.
- Request sampled in IDLE at edge N puts BUSY (and `mem_valid_o`=1) at cycle N+1. This is a registered output, with a 1-cycle grant latency.
- A zero-wait-state memory (`mem_ready_i` tied 1) completes a burst in LINE_WORDS cycles. Request to `done` takes 1+LINE_WORDS cycles minimum.
- IDLE always occupies at least one cycle between bursts; back-to-back bursts are spaced by that cycle.
- A request arriving during `done` is arbitrated in the following IDLE cycle.

## Structure
- A shared package `mem_pkg` holds:
  - the `arb_state_t` enum (`IDLE`, `BUSY_I`, `BUSY_D`)
  - the `requester_t` enum (`REQ_I`, `REQ_D`) used for `last_grant`
  - the `LINE_WORDS` default
- One natural sub-module, `rr_arb2`: a 2-way round-robin picker. Inputs are the two requests and `last_grant`; the outputs are the grant and the update enable. The remainder is the FSM, beat counter, and address generation.

## Test plan
- I-only read, `LINE_WORDS`=4, base 0x100, `mem_ready_i`=1 always -> `mem_addr_o` 0x100, 0x104, 0x108, 0x10C on consecutive cycles; four `i_rvalid_o`; `i_done_o` on the 4th; `i_stall_o` low the cycle after.
- Simultaneous I and D requests just after reset -> D granted first; I granted in the IDLE cycle after `d_done_o`. A second tie with both still requesting goes to D (I was last).
- D write, base 0x2000, `mem_ready_i` asserted every 3rd cycle -> `mem_we_o`=1 for 4 beats; `mem_wdata_o` tracks `d_wdata_i` per `beat_o` 0..3; no `d_rvalid_o`; single `d_done_o`.
- Address wrap: base 0xFFFF_FFF8 -> beat addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000, 0x0000_0004.
- `rst_n` low after beat 1 of an I burst -> all outputs 0 immediately. After release with no requests, `mem_valid_o` stays 0; a new request restarts at beat 0.
- `i_req_i` dropped mid-burst and stray `mem_ready_i` pulses in IDLE -> burst completes with `i_done_o`; stray pulses produce no `rvalid`/`done` and no state change.
